// File: rtl/quant_seq_ctrl.sv
// quant_seq_ctrl: walks one feature vector through the external Quantizer.
// For each feature it reads the buffer, quantizes the word, and hands
// {id, level} to the LUT stage over a valid/ready handshake.
// Optional build macro: QSEQ_STALL_CNT_EN adds a 32-bit stall_cnt output
// counting EMIT cycles spent waiting on out_ready.
module quant_seq_ctrl #(
    parameter int NUM_FEATURES = 617,
    parameter int ID_W         = 10,
    parameter int DATA_W       = 32,
    parameter int LEVEL_W      = 4,
    parameter int MAX_LEVEL    = 9
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               lvl_err,
    output logic               mem_rd_en,
    output logic [ID_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]  mem_rd_data,
    output logic               q_en,
    output logic [DATA_W-1:0]  q_value,
    input  logic [LEVEL_W-1:0] q_level,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ID_W-1:0]    out_id,
    output logic [LEVEL_W-1:0] out_level
`ifdef QSEQ_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_QUANT,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [ID_W-1:0]    LP_LAST_IDX = ID_W'(NUM_FEATURES - 1);
    localparam logic [LEVEL_W-1:0] LP_MAX_LVL  = LEVEL_W'(MAX_LEVEL);

    state_t               r_state;
    state_t               w_state_next;
    logic [ID_W-1:0]      r_idx;
    logic                 r_lvl_err;
    logic                 r_out_valid;
    logic [ID_W-1:0]      r_out_id;
    logic [LEVEL_W-1:0]   r_out_level;

    logic w_start_acc;
    logic w_handshake;
    logic w_last;

    assign w_start_acc = (r_state == S_IDLE) && start && !abort;
    assign w_handshake = (r_state == S_EMIT) && r_out_valid && out_ready;
    assign w_last      = (r_idx == LP_LAST_IDX);

    assign lvl_err   = r_lvl_err;
    assign out_valid = r_out_valid;
    assign out_id    = r_out_id;
    assign out_level = r_out_level;

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-state strobes; abort overrides every transition.
    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        mem_rd_en    = 1'b0;
        mem_addr     = '0;
        q_en         = 1'b0;
        q_value      = '0;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_rd_en    = 1'b1;
                mem_addr     = r_idx;
                w_state_next = S_QUANT;
            end
            S_QUANT: begin
                q_en         = 1'b1;
                q_value      = mem_rd_data;
                w_state_next = S_EMIT;
            end
            S_EMIT: begin
                if (w_handshake) w_state_next = w_last ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (abort) w_state_next = S_IDLE;
    end

    // Feature index: restarts on accepted start or abort, advances after each handshake.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_idx <= '0;
        end else if (abort || w_start_acc) begin
            r_idx <= '0;
        end else if (w_handshake && !w_last) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Output register: captured from the Quantizer in QUANT, held until the LUT accepts.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_out_level <= '0;
        end else if (abort) begin
            r_out_valid <= 1'b0;
        end else if (r_state == S_QUANT) begin
            r_out_valid <= 1'b1;
            r_out_id    <= r_idx;
            r_out_level <= q_level;
        end else if (w_handshake) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky out-of-range flag; the level itself is forwarded unchanged.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_lvl_err <= 1'b0;
        end else if (w_start_acc) begin
            r_lvl_err <= 1'b0;
        end else if (!abort && (r_state == S_QUANT) && (q_level > LP_MAX_LVL)) begin
            r_lvl_err <= 1'b1;
        end
    end

`ifdef QSEQ_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    assign stall_cnt = r_stall_cnt;

    // Saturating count of EMIT cycles blocked by the LUT.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_EMIT) && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
